// File: rtl/vfat3_daq_crc_checker.sv
// ---------------------------------------------------------------------------
// vfat3_daq_crc_checker
//
// Receive-side CRC16-CCITT checker for one VFAT3 DAQ link. It consumes the
// deframed byte stream. For each packet it runs the CRC over the payload and
// the 2-byte trailer, which the VFAT3 data formatter appended MSB first.
// A zero residue means the packet is intact. The verdict is a registered
// one-cycle pulse, issued one cycle after the eop beat.
//
// Ports
//   clk           : single clock, rising edge
//   reset_n       : asynchronous, active-low reset
//   resync_i      : synchronous clear; aborts the packet, zeroes the counters
//   data_i        : packet byte
//   data_valid_i  : data_i valid this cycle (gaps allowed anywhere)
//   sop_i, eop_i  : first / last byte markers, qualified by data_valid_i
//   crc_ok_o      : pulse, packet CRC matched
//   crc_err_o     : pulse, packet CRC mismatched
//   len_err_o     : pulse, packet shorter than 3 bytes or aborted by a new sop
//   crc_calc_o    : payload-only CRC of the last checked packet
//   crc_rx_o      : received trailer {first byte, last byte}
//   pkt_cnt_o     : completed packets (ok + err + len_err), saturating
//   err_cnt_o     : crc_err + len_err events, saturating
//
// Build option
//   VFAT3_CRC_CNT_EN : when defined, the saturating packet and error
//                      counters are built. When undefined, pkt_cnt_o and
//                      err_cnt_o are tied to zero.
// ---------------------------------------------------------------------------
module vfat3_daq_crc_checker #(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = 16,
  parameter logic [CRC_WIDTH-1:0] INIT_VAL   = 16'hFFFF,
  parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
  parameter int                   CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  resync_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  output logic                  crc_ok_o,
  output logic                  crc_err_o,
  output logic                  len_err_o,
  output logic [CRC_WIDTH-1:0]  crc_calc_o,
  output logic [CRC_WIDTH-1:0]  crc_rx_o,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Processes one byte, MSB first, with no reflection and no final XOR.
  function automatic logic [CRC_WIDTH-1:0] crc_step(
    input logic [CRC_WIDTH-1:0]  crc_in,
    input logic [DATA_WIDTH-1:0] byte_in
  );
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = crc_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = byte_in[i] ^ c[CRC_WIDTH-1];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  state_e                state_q, state_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;          // running CRC, through the last byte
  logic [CRC_WIDTH-1:0]  crc_d1_q, crc_d1_d;    // running CRC one byte earlier
  logic [DATA_WIDTH-1:0] prev_byte_q, prev_byte_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d; // saturates at 3
  logic                  crc_ok_q, crc_ok_d;
  logic                  crc_err_q, crc_err_d;
  logic                  len_err_q, len_err_d;
  logic [CRC_WIDTH-1:0]  crc_calc_q, crc_calc_d;
  logic [CRC_WIDTH-1:0]  crc_rx_q, crc_rx_d;

  logic [CRC_WIDTH-1:0]  crc_seed;
  logic [CRC_WIDTH-1:0]  crc_next;

  assign crc_seed = crc_step(INIT_VAL, data_i);
  assign crc_next = crc_step(crc_q, data_i);

  // On the eop beat, crc_q already covers the trailer MSB. The payload-only
  // CRC is therefore crc_d1_q, the state before that byte. One history stage
  // is enough because the verdict is formed on the eop beat itself.
  always_comb begin
    // NOTE: every signal gets its hold/idle value first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    state_d     = state_q;
    crc_d       = crc_q;
    crc_d1_d    = crc_d1_q;
    prev_byte_d = prev_byte_q;
    byte_cnt_d  = byte_cnt_q;
    crc_ok_d    = 1'b0;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    crc_calc_d  = crc_calc_q;
    crc_rx_d    = crc_rx_q;

    if (resync_i) begin
      state_d    = ST_IDLE;
      byte_cnt_d = 2'd0;
    end else if (data_valid_i) begin
      prev_byte_d = data_i;
      if (sop_i) begin
        // A sop while in RUN aborts the open packet. A sop+eop beat is a
        // 1-byte packet. Either case raises a single length error.
        if (state_q == ST_RUN || eop_i) begin
          len_err_d = 1'b1;
        end
        if (eop_i) begin
          state_d    = ST_IDLE;
          byte_cnt_d = 2'd0;
        end else begin
          state_d    = ST_RUN;
          crc_d      = crc_seed;
          crc_d1_d   = INIT_VAL;
          byte_cnt_d = 2'd1;
        end
      end else if (state_q == ST_RUN) begin
        crc_d      = crc_next;
        crc_d1_d   = crc_q;
        byte_cnt_d = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;
        if (eop_i) begin
          state_d    = ST_IDLE;
          byte_cnt_d = 2'd0;
          // byte_cnt_q counts earlier beats, so >= 2 means >= 3 with this one.
          if (byte_cnt_q >= 2'd2) begin
            crc_ok_d   = (crc_next == '0);
            crc_err_d  = (crc_next != '0);
            crc_calc_d = crc_d1_q;
            crc_rx_d   = {prev_byte_q, data_i};
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the whole datapath is only a few flops, so every register is
  // reset. This lets the outputs read as zero straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= '0;
      crc_d1_q    <= '0;
      prev_byte_q <= '0;
      byte_cnt_q  <= 2'd0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      crc_calc_q  <= '0;
      crc_rx_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so that every flop samples the
      // pre-edge value of every other flop, independent of statement order.
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_d1_q    <= crc_d1_d;
      prev_byte_q <= prev_byte_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      crc_calc_q  <= crc_calc_d;
      crc_rx_q    <= crc_rx_d;
    end
  end

  assign crc_ok_o   = crc_ok_q;
  assign crc_err_o  = crc_err_q;
  assign len_err_o  = len_err_q;
  assign crc_calc_o = crc_calc_q;
  assign crc_rx_o   = crc_rx_q;

`ifdef VFAT3_CRC_CNT_EN
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // The counters follow the registered pulses, so they move one cycle after
  // the verdict is visible.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (resync_i) begin
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if ((crc_ok_q || crc_err_q || len_err_q) && (pkt_cnt_q != '1)) begin
        pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
      if ((crc_err_q || len_err_q) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
`else
  assign pkt_cnt_o = '0;
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vfat3_daq_crc_checker.sv
// ---------------------------------------------------------------------------
// tb_vfat3_daq_crc_checker
//
// Directed bench with a scoreboard. The stimulus tasks push the expected
// verdict, its CRC values and its due cycle at the moment they drive the
// closing beat. A monitor on the falling edge pops an entry whenever a
// verdict pulse appears and compares the two. Counter values are checked
// directly after quiet cycles. A second instance with CNT_WIDTH=2 shares the
// stimulus and exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_vfat3_daq_crc_checker;

`ifdef VFAT3_CRC_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {V_OK = 2'd0, V_ERR = 2'd1, V_LEN = 2'd2} vkind_e;

  typedef struct packed {
    vkind_e      kind;
    logic [15:0] calc;
    logic [15:0] rx;
    int          due;
  } verdict_t;

  typedef logic [7:0] pkt_t [16];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        resync_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        data_valid_i = 1'b0;
  logic        sop_i = 1'b0;
  logic        eop_i = 1'b0;

  logic        crc_ok_o, crc_err_o, len_err_o;
  logic [15:0] crc_calc_o, crc_rx_o;
  logic [15:0] pkt_cnt_o, err_cnt_o;

  logic        s_ok, s_err, s_len;
  logic [15:0] s_calc, s_rx;
  logic [1:0]  s_pkt_cnt, s_err_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  verdict_t    exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vfat3_daq_crc_checker #(.CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .resync_i     (resync_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .sop_i        (sop_i),
    .eop_i        (eop_i),
    .crc_ok_o     (crc_ok_o),
    .crc_err_o    (crc_err_o),
    .len_err_o    (len_err_o),
    .crc_calc_o   (crc_calc_o),
    .crc_rx_o     (crc_rx_o),
    .pkt_cnt_o    (pkt_cnt_o),
    .err_cnt_o    (err_cnt_o)
  );

  vfat3_daq_crc_checker #(.CNT_WIDTH(2)) dut_sat (
    .clk          (clk),
    .reset_n      (reset_n),
    .resync_i     (resync_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .sop_i        (sop_i),
    .eop_i        (eop_i),
    .crc_ok_o     (s_ok),
    .crc_err_o    (s_err),
    .len_err_o    (s_len),
    .crc_calc_o   (s_calc),
    .crc_rx_o     (s_rx),
    .pkt_cnt_o    (s_pkt_cnt),
    .err_cnt_o    (s_err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cexp(input int v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  // Scoreboard monitor.
  verdict_t mon_e;
  vkind_e   mon_k;
  always @(negedge clk) begin
    if (reset_n && (crc_ok_o || crc_err_o || len_err_o)) begin
      check("pulse_onehot", 32'($countones({crc_ok_o, crc_err_o, len_err_o})), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, crc_ok_o, crc_err_o, len_err_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_k = crc_ok_o ? V_OK : (crc_err_o ? V_ERR : V_LEN);
        check("verdict_kind",    32'(mon_k),    32'(mon_e.kind));
        check("verdict_latency", 32'(cyc),      32'(mon_e.due));
        check("crc_calc",        32'(crc_calc_o), 32'(mon_e.calc));
        check("crc_rx",          32'(crc_rx_o),   32'(mon_e.rx));
      end
    end
  end

  // Drives one cycle of inputs, then moves to 1 time unit after the edge.
  task automatic beat(input logic [7:0] d, input logic v, input logic s, input logic e);
    data_i       = d;
    data_valid_i = v;
    sop_i        = s;
    eop_i        = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends n bytes of b. A set bit in gaps inserts an invalid beat before
  // that byte, with sop/eop raised as noise. Pushes the expected abort
  // verdict at the first beat and the closing verdict at the eop beat.
  task automatic send_pkt(input pkt_t b, input int n, input logic [15:0] gaps,
                          input bit do_eop, input bit push_v, input vkind_e k,
                          input logic [15:0] c, input logic [15:0] r,
                          input bit push_abort, input logic [15:0] ac,
                          input logic [15:0] ar);
    for (int i = 0; i < n; i++) begin
      if (gaps[i]) beat(8'hEE, 1'b0, 1'b1, 1'b1);
      if (i == 0 && push_abort) exp_q.push_back('{V_LEN, ac, ar, cyc + 1});
      if (i == n - 1 && do_eop && push_v) exp_q.push_back('{k, c, r, cyc + 1});
      beat(b[i], 1'b1, (i == 0), (do_eop && (i == n - 1)));
    end
    data_valid_i = 1'b0;
    sop_i        = 1'b0;
    eop_i        = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ok"},   32'(crc_ok_o),   32'd0);
    check({tag, "_err"},  32'(crc_err_o),  32'd0);
    check({tag, "_len"},  32'(len_err_o),  32'd0);
    check({tag, "_calc"}, 32'(crc_calc_o), 32'd0);
    check({tag, "_rx"},   32'(crc_rx_o),   32'd0);
    check({tag, "_pkt"},  32'(pkt_cnt_o),  32'd0);
    check({tag, "_errc"}, 32'(err_cnt_o),  32'd0);
  endtask

  task automatic check_cnt(input string tag, input int p, input int e);
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt_o), cexp(p));
    check({tag, "_err_cnt"}, 32'(err_cnt_o), cexp(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t good, bad, shrt, min_ok, min_bad, single;
    int   wait_cyc;
    for (int i = 0; i < 16; i++) begin
      good[i] = 8'h00; bad[i] = 8'h00; shrt[i] = 8'h00;
      min_ok[i] = 8'h00; min_bad[i] = 8'h00; single[i] = 8'h00;
    end
    for (int i = 0; i < 9; i++) good[i] = 8'h31 + 8'(i);
    good[9]  = 8'h29;
    good[10] = 8'hB1;
    bad      = good;
    bad[10]  = 8'hB0;
    shrt[0]  = 8'h31; shrt[1] = 8'hC7;
    // CRC16-CCITT (init FFFF) of the single byte 0x31 is 0xC782.
    min_ok[0]  = 8'h31; min_ok[1]  = 8'hC7; min_ok[2]  = 8'h82;
    min_bad[0] = 8'h31; min_bad[1] = 8'hC7; min_bad[2] = 8'h83;
    single[0]  = 8'h31;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Good packet "123456789" + 0x29B1.
    send_pkt(good, 11, 16'h0000, 1, 1, V_OK, 16'h29B1, 16'h29B1, 0, 16'h0, 16'h0);
    idle(3);
    check_cnt("good", 1, 0);

    // Corrupt trailer.
    send_pkt(bad, 11, 16'h0000, 1, 1, V_ERR, 16'h29B1, 16'h29B0, 0, 16'h0, 16'h0);
    idle(3);
    check_cnt("corrupt", 2, 1);

    // Gapped packet, then an immediate back-to-back packet.
    send_pkt(good, 11, 16'b0000_0101_0010_0110, 1, 1, V_OK, 16'h29B1, 16'h29B1, 0, 16'h0, 16'h0);
    send_pkt(good, 11, 16'h0000, 1, 1, V_OK, 16'h29B1, 16'h29B1, 0, 16'h0, 16'h0);
    idle(3);
    check_cnt("b2b", 4, 1);

    // Two-byte packet: length error, CRC outputs held.
    send_pkt(shrt, 2, 16'h0000, 1, 1, V_LEN, 16'h29B1, 16'h29B1, 0, 16'h0, 16'h0);
    idle(3);
    check_cnt("short", 5, 2);

    // Abort after 5 bytes by a new sop, then the full good packet.
    send_pkt(good, 5, 16'h0000, 0, 0, V_OK, 16'h0, 16'h0, 0, 16'h0, 16'h0);
    send_pkt(good, 11, 16'h0000, 1, 1, V_OK, 16'h29B1, 16'h29B1, 1, 16'h29B1, 16'h29B1);
    idle(3);
    check_cnt("abort", 7, 3);

    // Minimum-length packets: pass and fail.
    send_pkt(min_ok, 3, 16'h0000, 1, 1, V_OK, 16'hC782, 16'hC782, 0, 16'h0, 16'h0);
    send_pkt(min_bad, 3, 16'h0000, 1, 1, V_ERR, 16'hC782, 16'hC783, 0, 16'h0, 16'h0);
    idle(3);
    check_cnt("min3", 9, 4);

    // sop and eop on the same beat.
    send_pkt(single, 1, 16'h0000, 1, 1, V_LEN, 16'hC782, 16'hC783, 0, 16'h0, 16'h0);
    idle(3);
    check_cnt("single", 10, 5);

    // Resync after 4 bytes: no pulse, counters cleared, CRC outputs held.
    send_pkt(good, 4, 16'h0000, 0, 0, V_OK, 16'h0, 16'h0, 0, 16'h0, 16'h0);
    resync_i = 1'b1;
    idle(1);
    resync_i = 1'b0;
    idle(3);
    check_cnt("resync", 0, 0);
    check("resync_calc_held", 32'(crc_calc_o), 32'h0000C782);
    check("resync_rx_held",   32'(crc_rx_o),   32'h0000C783);

    // Good packet after the resync.
    send_pkt(good, 11, 16'h0000, 1, 1, V_OK, 16'h29B1, 16'h29B1, 0, 16'h0, 16'h0);
    idle(3);
    check_cnt("post_resync", 1, 0);

    // Reset in the middle of a packet.
    send_pkt(good, 6, 16'h0000, 0, 0, V_OK, 16'h0, 16'h0, 0, 16'h0, 16'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
    check_zero("post_reset");

    // Five back-to-back bad packets: saturation on the 2-bit instance.
    for (int p = 0; p < 5; p++) begin
      send_pkt(bad, 11, 16'h0000, 1, 1, V_ERR, 16'h29B1, 16'h29B0, 0, 16'h0, 16'h0);
    end
    idle(3);
    check_cnt("five_bad", 5, 5);
    check("sat_pkt_cnt", 32'(s_pkt_cnt), cexp(3));
    check("sat_err_cnt", 32'(s_err_cnt), cexp(3));

    // Every expected verdict must have been seen.
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      idle(1);
      wait_cyc++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
